// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared sample/beat types and frame geometry for dft64    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_LEN  = 64;
  localparam int BEAT_LEN   = 8;
  localparam int WR_IDX_W   = $clog2(FRAME_LEN);
  localparam int BEAT_IDX_W = $clog2(FRAME_LEN / BEAT_LEN);
  localparam int LANE_W     = $clog2(BEAT_LEN);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Element BEAT_LEN-1 is the first sample of the beat and lands in the MSBs.
  typedef sample_t [BEAT_LEN-1:0] beat_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/frame_buf64.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_buf64 : 64x16 register file, one write port, 8-wide read     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module frame_buf64
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [WR_IDX_W-1:0]   waddr,
  input  sample_t               wdata,
  input  logic [BEAT_IDX_W-1:0] raddr,
  output beat_t                 rdata
);

  sample_t r_mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < BEAT_LEN; i++) begin : g_rd
    assign rdata[BEAT_LEN-1-i] = r_mem[{raddr, LANE_W'(i)}];
  end

endmodule
`default_nettype wire

// File: rtl/dft64_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dft64_frame_loader : serial sample collector feeding dft64 beats   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dft64_frame_loader
  import fft_pkg::*;
#(
  parameter int DONE_TIMEOUT = 6
) (
  input  logic                         clk,
  input  logic                         sreset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SAMPLE_W-1:0]          in_sample,
  output logic [BEAT_LEN*SAMPLE_W-1:0] samples,
  output logic                         rel,
  output logic                         calculate,
  input  logic                         done,
  output logic                         busy,
  output logic                         frame_sent,
  output logic                         timeout_err
);

  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);

  loader_state_e               r_state, w_state_nxt;
  logic [WR_IDX_W-1:0]         r_wr_idx, w_wr_nxt;
  logic [BEAT_IDX_W-1:0]       r_beat_idx, w_beat_nxt;
  logic [WAIT_W-1:0]           r_wait_cnt, w_wait_nxt;

  logic                        r_in_ready, r_rel, r_calc, r_busy, r_sent, r_tmo;
  logic [BEAT_LEN*SAMPLE_W-1:0] r_samples;

  logic                        w_in_ready_nxt, w_rel_nxt, w_calc_nxt, w_busy_nxt;
  logic                        w_sent_nxt, w_tmo_nxt;
  logic [BEAT_LEN*SAMPLE_W-1:0] w_samples_nxt;

  logic                        w_accept, w_done_hit, w_timeout_hit;
  beat_t                       w_beat;

  assign w_accept      = in_valid && r_in_ready;
  assign w_done_hit    = (r_state == WAIT_DONE) && done;
  // done takes priority when it lands on the final count
  assign w_timeout_hit = (r_state == WAIT_DONE) && !done &&
                         (r_wait_cnt == WAIT_W'(DONE_TIMEOUT - 1));

  // Read port looks ahead to the next beat so the samples register lines up
  frame_buf64 u_buf (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wr_idx),
    .wdata (in_sample),
    .raddr (w_beat_nxt),
    .rdata (w_beat)
  );

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state    <= FILL;
      r_wr_idx   <= '0;
      r_beat_idx <= '0;
      r_wait_cnt <= '0;
      r_in_ready <= 1'b1;
      r_rel      <= 1'b0;
      r_calc     <= 1'b0;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
      r_tmo      <= 1'b0;
      r_samples  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_idx   <= w_wr_nxt;
      r_beat_idx <= w_beat_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_rel      <= w_rel_nxt;
      r_calc     <= w_calc_nxt;
      r_busy     <= w_busy_nxt;
      r_sent     <= w_sent_nxt;
      r_tmo      <= w_tmo_nxt;
      r_samples  <= w_samples_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_idx;
    w_beat_nxt  = r_beat_idx;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr_nxt = r_wr_idx + 1'b1;
          if (r_wr_idx == WR_IDX_W'(FRAME_LEN - 1)) begin
            w_state_nxt = SEND;
            w_beat_nxt  = '0;
          end
        end
      end
      SEND: begin
        if (r_beat_idx == BEAT_IDX_W'(FRAME_LEN / BEAT_LEN - 1)) begin
          w_state_nxt = WAIT_DONE;
          w_wait_nxt  = '0;
        end else begin
          w_beat_nxt = r_beat_idx + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (w_done_hit || w_timeout_hit) begin
          w_state_nxt = FILL;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_comb begin
    w_in_ready_nxt = (w_state_nxt == FILL);
    w_busy_nxt     = (w_state_nxt != FILL);
    w_calc_nxt     = (w_state_nxt != FILL);
    w_rel_nxt      = (w_state_nxt == SEND);
    w_samples_nxt  = (w_state_nxt == SEND) ? w_beat : '0;
    w_sent_nxt     = w_done_hit;
    w_tmo_nxt      = w_timeout_hit;
  end

  assign in_ready    = r_in_ready;
  assign rel         = r_rel;
  assign calculate   = r_calc;
  assign busy        = r_busy;
  assign frame_sent  = r_sent;
  assign timeout_err = r_tmo;
  assign samples     = r_samples;

endmodule
`default_nettype wire

// File: tb/tb_dft64_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dft64_frame_loader : table-driven and randomized frame checks   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dft64_frame_loader;

  localparam int TO = 6;

  logic         clk = 1'b0;
  logic         sreset, in_valid, in_ready, rel, calculate, done, busy;
  logic         frame_sent, timeout_err;
  logic [15:0]  in_sample;
  logic [127:0] samples;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] frame [64];

  typedef struct {
    int kind;       // 0 ramp, 1 sine, 2 random, 3 ramp with sign bit
    int mode;       // 0 continuous, 1 alternate valid, 2 random valid
    int d;          // done edge after WAIT_DONE entry, 0 = never
    int done_beat;  // beat during which a stray done is driven, -1 none
    int rst_beat;   // beat during which sreset is driven, -1 none
    bit exp_sent;
    bit exp_tmo;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  dft64_frame_loader #(.DONE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .sreset      (sreset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .samples     (samples),
    .rel         (rel),
    .calculate   (calculate),
    .done        (done),
    .busy        (busy),
    .frame_sent  (frame_sent),
    .timeout_err (timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Beat b carries samples 8b..8b+7, first one in the top 16 bits
  function automatic logic [127:0] exp_beat(input int b);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[(7 - i) * 16 +: 16] = frame[8 * b + i];
    return v;
  endfunction

  task automatic make_frame(input int kind);
    for (int n = 0; n < 64; n++) begin
      case (kind)
        0: frame[n] = 16'(n);
        1: frame[n] = 16'(int'($sin(2.0 * 3.14159265358979 * n / 48.0) * 256.0));
        3: frame[n] = 16'h8000 | 16'(n * 3);
        default: frame[n] = 16'($urandom);
      endcase
    end
  endtask

  task automatic fill(input int mode);
    int  k;
    int  cyc;
    logic acc;
    k   = 0;
    cyc = 0;
    while (k < 64 && cyc < 2000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_sample = frame[k];
      acc = in_valid && in_ready;
      tick;
      cyc++;
      if (acc) k++;
    end
    chki("fill_count", k, 64);
    if (mode == 0) chki("fill_cycles", cyc, 64);
    if (mode == 1) chki("fill_cycles", cyc, 128);
    // keep valid asserted while busy to prove it is not consumed
    in_valid  = (mode == 1);
    in_sample = 16'hDEAD;
  endtask

  task automatic run_frame(input vec_t v);
    int end_j;
    make_frame(v.kind);
    fill(v.mode);
    for (int b = 0; b < 8; b++) begin
      chk1($sformatf("rel_b%0d", b), rel, 1'b1);
      chkv($sformatf("beat%0d", b), samples, exp_beat(b));
      chk1("calc_send", calculate, 1'b1);
      chk1("ready_send", in_ready, 1'b0);
      chk1("busy_send", busy, 1'b1);
      if (b == v.rst_beat) begin
        sreset   = 1'b1;
        in_valid = 1'b0;
        tick;
        sreset = 1'b0;
        chk1("rst_rel", rel, 1'b0);
        chk1("rst_calc", calculate, 1'b0);
        chkv("rst_samples", samples, '0);
        chk1("rst_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        for (int t = 0; t < 8; t++) begin
          chk1("rst_no_sent", frame_sent, 1'b0);
          chk1("rst_no_tmo", timeout_err, 1'b0);
          tick;
        end
        return;
      end
      done = (b == v.done_beat);
      tick;
      done = 1'b0;
    end
    chk1("wait_rel", rel, 1'b0);
    chkv("wait_samples", samples, '0);
    chk1("wait_calc", calculate, 1'b1);
    chk1("wait_ready", in_ready, 1'b0);
    end_j = (v.d >= 1 && v.d <= TO) ? v.d : TO;
    for (int j = 1; j <= end_j; j++) begin
      done = (j == v.d);
      tick;
      done = 1'b0;
      if (j < end_j) begin
        chk1("early_sent", frame_sent, 1'b0);
        chk1("early_tmo", timeout_err, 1'b0);
        chk1("early_calc", calculate, 1'b1);
      end
    end
    in_valid = 1'b0;
    chk1("end_sent", frame_sent, v.exp_sent);
    chk1("end_tmo", timeout_err, v.exp_tmo);
    chk1("end_calc", calculate, 1'b0);
    chk1("end_ready", in_ready, 1'b1);
    chk1("end_busy", busy, 1'b0);
    tick;
    chk1("pulse_sent", frame_sent, 1'b0);
    chk1("pulse_tmo", timeout_err, 1'b0);
  endtask

  initial begin
    vec_t rv;
    vt[0] = '{0, 0, 3, -1, -1, 1'b1, 1'b0};
    vt[1] = '{1, 0, 3, -1, -1, 1'b1, 1'b0};
    vt[2] = '{0, 1, 2, -1, -1, 1'b1, 1'b0};
    vt[3] = '{2, 0, 0, -1, -1, 1'b0, 1'b1};
    vt[4] = '{3, 0, 1, -1, -1, 1'b1, 1'b0};
    vt[5] = '{2, 2, 6,  3, -1, 1'b1, 1'b0};
    vt[6] = '{2, 0, 0, -1,  4, 1'b0, 1'b0};
    vt[7] = '{0, 2, 4, -1, -1, 1'b1, 1'b0};

    sreset    = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    done      = 1'b0;
    tick;
    tick;
    chk1("reset_ready", in_ready, 1'b1);
    chk1("reset_rel", rel, 1'b0);
    chk1("reset_calc", calculate, 1'b0);
    chkv("reset_samples", samples, '0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_sent", frame_sent, 1'b0);
    chk1("reset_tmo", timeout_err, 1'b0);
    sreset = 1'b0;

    // abandon a partial frame after 20 accepts
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sample = 16'($urandom);
      tick;
    end
    chk1("midfill_busy", busy, 1'b0);
    sreset   = 1'b1;
    in_valid = 1'b0;
    tick;
    sreset = 1'b0;
    chk1("midfill_rst_ready", in_ready, 1'b1);

    for (int t = 0; t < 8; t++) run_frame(vt[t]);

    for (int r = 0; r < 4; r++) begin
      rv.kind      = 2;
      rv.mode      = 2;
      rv.d         = int'($urandom_range(0, 8));
      rv.done_beat = int'($urandom_range(0, 9)) - 1;
      rv.rst_beat  = -1;
      rv.exp_sent  = (rv.d >= 1 && rv.d <= TO);
      rv.exp_tmo   = !rv.exp_sent;
      run_frame(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
